taxi_eth_mac_rx_stat_cnt: RTL and testbench
===========================================

// Module: taxi_eth_mac_rx_stat_cnt
// PURPOSE
//  Downstream consumer of the 10G MAC RX status pulses (rx_clk domain). Accumulates the
//  seven single-cycle RX status strobes into per-event counters, takes atomic snapshots
//  into shadow registers, and serves snapshot values over a valid/ready read channel.
//  Gives management logic coherent RX error/packet statistics without a clock crossing.
// PARAMETERS
//  CNT_W        32   counter and rd_data width (8..48)
//  SATURATE     1    1: counters stick at 2^CNT_W-1; 0: counters wrap to 0
//  CLR_ON_SNAP  0    1: live counters restart from the same-cycle event after each snapshot
// PORTS
//  rx_clk               in   1      clock
//  rx_rst               in   1      asynchronous reset, active-high
//  stat_rx_pkt_good     in   1      event strobe, idx 0
//  stat_rx_pkt_bad      in   1      event strobe, idx 1
//  stat_rx_err_bad_fcs  in   1      event strobe, idx 2
//  stat_rx_err_preamble in   1      event strobe, idx 3
//  stat_rx_err_framing  in   1      event strobe, idx 4
//  stat_rx_err_oversize in   1      event strobe, idx 5
//  stat_rx_pkt_fragment in   1      event strobe, idx 6
//  clr                  in   1      1-cycle pulse: zero live counters and overflow flags
//  snap                 in   1      1-cycle pulse: copy live counters into shadow regs
//  rd_req_valid         in   1      read request valid
//  rd_req_ready         out  1      read request ready
//  rd_req_addr          in   3      0..6 shadow counter idx; 7 = sticky overflow vector
//  rd_resp_valid        out  1      read response valid
//  rd_resp_ready        in   1      read response ready
//  rd_resp_data         out  CNT_W  shadow value; addr 7: {zeros, ovf[6:0]}
// BEHAVIOUR
//  Reset: all live counters, shadows, ovf[6:0] = 0; rd_req_ready=1, rd_resp_valid=0,
//   rd_resp_data=0; FSM in IDLE. Reset mid-transaction drops the pending response.
//  Counting: strobe high at edge N -> live counter +1 visible at edge N+1. Strobes are
//   independent; any subset may be high in one cycle, each counted once.
//  Width: increment at 2^CNT_W-1 sets ovf[i] (sticky); SATURATE=1 holds at max,
//   SATURATE=0 wraps to 0. ovf set is the same in both modes.
//  clr: live counters and ovf <- 0; strobe in the same cycle wins over clr: counter <- 1.
//   Shadows are NOT cleared by clr.
//  snap: shadow[i] <- live[i] pre-increment value (same-cycle strobe excluded from shadow).
//   CLR_ON_SNAP=0: live counts on normally. CLR_ON_SNAP=1: live[i] <- strobe_i ? 1 : 0.
//   snap and clr together: shadow captures pre-clear value, then clr rules apply to live.
//   No event is ever lost or double-counted across snap/clr.
//  Read FSM:
//   IDLE: rd_req_ready=1. On rd_req_valid: latch addr, select shadow/ovf into
//    rd_resp_data, go RESP (1-cycle latency: rd_resp_valid high the next cycle).
//   RESP: rd_req_ready=0, rd_resp_valid=1, rd_resp_data stable until rd_resp_ready;
//    on rd_resp_ready go IDLE (back-to-back: new request accepted the following cycle).
//   rd_resp_data reflects shadows at accept time; a snap during RESP does not alter it.
//   Addr 7 reads live ovf[6:0] (not shadowed), zero-extended to CNT_W.
//  Throughput: one read per 2 cycles max; counting never stalls on reads.
// TESTING
//  1. Reset, 5 good strobes, snap, read addr 0 -> rd_resp_data=5; addr 1 -> 0.
//  2. All 7 strobes high for 3 consecutive cycles, snap, read 0..6 -> each =3.
//  3. CNT_W=8, SATURATE=1: 260 fcs strobes -> addr 2 =255, addr 7 =0x04; SATURATE=0 ->
//     addr 2 =4, addr 7 =0x04; then clr+snap -> addr 2 =0, addr 7 =0.
//  4. Counter at 10, snap+clr+strobe same cycle, snap next cycle -> first shadow 10,
//     second shadow 1.
//  5. CLR_ON_SNAP=1: 4 strobes, snap with strobe -> shadow 4; 2 more, snap -> shadow 3.
//  6. Hold rd_resp_ready=0 for 10 cycles while snapping -> data stable, rd_req_ready=0;
//     assert rx_rst mid-RESP -> rd_resp_valid=0 immediately, all reads then return 0.

Source files
------------

// File: rtl/taxi_eth_mac_rx_stat_cnt.sv
// RX status strobe counters with atomic snapshot shadows and a valid/ready read port.
// Counting has zero stall; read response appears one cycle after accept and is held until rd_resp_ready.
module taxi_eth_mac_rx_stat_cnt #(
  parameter int CNT_W       = 32,
  parameter bit SATURATE    = 1'b1,
  parameter bit CLR_ON_SNAP = 1'b0
) (
  input  logic             rx_clk,
  input  logic             rx_rst,
  input  logic             stat_rx_pkt_good,
  input  logic             stat_rx_pkt_bad,
  input  logic             stat_rx_err_bad_fcs,
  input  logic             stat_rx_err_preamble,
  input  logic             stat_rx_err_framing,
  input  logic             stat_rx_err_oversize,
  input  logic             stat_rx_pkt_fragment,
  input  logic             clr,
  input  logic             snap,
  input  logic             rd_req_valid,
  output logic             rd_req_ready,
  input  logic [2:0]       rd_req_addr,
  output logic             rd_resp_valid,
  input  logic             rd_resp_ready,
  output logic [CNT_W-1:0] rd_resp_data
);

  localparam int NEV = 7;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic {ST_IDLE, ST_RESP} state_e;

  logic [NEV-1:0]   ev;
  logic             restart;
  logic [CNT_W-1:0] live_q   [NEV];
  logic [CNT_W-1:0] live_d   [NEV];
  logic [CNT_W-1:0] shadow_q [NEV];
  logic [CNT_W-1:0] shadow_d [NEV];
  logic [NEV-1:0]   ovf_q, ovf_d;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] rdata_q, rdata_d;
  logic [CNT_W-1:0] rd_sel;

  assign ev = {stat_rx_pkt_fragment, stat_rx_err_oversize, stat_rx_err_framing,
               stat_rx_err_preamble, stat_rx_err_bad_fcs, stat_rx_pkt_bad, stat_rx_pkt_good};

  // A restart reloads the counter from the same-cycle strobe so no event is dropped.
  assign restart = clr | (snap & CLR_ON_SNAP);

  always_comb begin
    ovf_d = clr ? '0 : ovf_q;
    for (int i = 0; i < NEV; i++) begin
      live_d[i]   = live_q[i];
      shadow_d[i] = snap ? live_q[i] : shadow_q[i];
      if (restart) begin
        live_d[i] = {{(CNT_W-1){1'b0}}, ev[i]};
      end else if (ev[i]) begin
        if (live_q[i] == CNT_MAX) begin
          ovf_d[i]  = 1'b1;
          live_d[i] = SATURATE ? CNT_MAX : '0;
        end else begin
          live_d[i] = live_q[i] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    rd_sel = '0;
    if (rd_req_addr == 3'd7) begin
      rd_sel = {{(CNT_W-NEV){1'b0}}, ovf_q};
    end else begin
      for (int i = 0; i < NEV; i++) begin
        if (rd_req_addr == 3'(i)) rd_sel = shadow_q[i];
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    rdata_d       = rdata_q;
    rd_req_ready  = 1'b0;
    rd_resp_valid = 1'b0;
    case (state_q)
      ST_IDLE: begin
        rd_req_ready = 1'b1;
        if (rd_req_valid) begin
          rdata_d = rd_sel;
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        rd_resp_valid = 1'b1;
        if (rd_resp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign rd_resp_data = rdata_q;

  always_ff @(posedge rx_clk or posedge rx_rst) begin
    if (rx_rst) begin
      for (int i = 0; i < NEV; i++) begin
        live_q[i]   <= '0;
        shadow_q[i] <= '0;
      end
      ovf_q   <= '0;
      state_q <= ST_IDLE;
      rdata_q <= '0;
    end else begin
      for (int i = 0; i < NEV; i++) begin
        live_q[i]   <= live_d[i];
        shadow_q[i] <= shadow_d[i];
      end
      ovf_q   <= ovf_d;
      state_q <= state_d;
      rdata_q <= rdata_d;
    end
  end

endmodule

// File: tb/tb_taxi_eth_mac_rx_stat_cnt.sv
// Three DUT flavours (8-bit saturating, 8-bit wrapping, 16-bit clear-on-snap) share one stimulus stream;
// an event-count reference model feeds per-instance expected-response queues checked by a negedge monitor.
module tb_taxi_eth_mac_rx_stat_cnt;

  localparam int NI = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] ev;
  logic       clr, snap, rvld, rrdy;
  logic [2:0] raddr;
  logic [NI-1:0] req_rdy, resp_vld;
  logic [15:0]   dat [NI];
  bit            mon_en;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int GW = (g == 2) ? 16 : 8;
    logic [GW-1:0] d;
    taxi_eth_mac_rx_stat_cnt #(
      .CNT_W(GW), .SATURATE(g != 1), .CLR_ON_SNAP(g == 2)
    ) u_dut (
      .rx_clk(clk), .rx_rst(rst),
      .stat_rx_pkt_good(ev[0]), .stat_rx_pkt_bad(ev[1]), .stat_rx_err_bad_fcs(ev[2]),
      .stat_rx_err_preamble(ev[3]), .stat_rx_err_framing(ev[4]),
      .stat_rx_err_oversize(ev[5]), .stat_rx_pkt_fragment(ev[6]),
      .clr(clr), .snap(snap),
      .rd_req_valid(rvld), .rd_req_ready(req_rdy[g]), .rd_req_addr(raddr),
      .rd_resp_valid(resp_vld[g]), .rd_resp_ready(rrdy), .rd_resp_data(d)
    );
    assign dat[g] = 16'(d);
  end

  // Reference model: e counts events since the last clear/restart; value derived arithmetically.
  longint      e  [NI][7];
  longint      sh [NI][7];
  logic [6:0]  ovf [NI];
  bit          busy [NI];
  logic [15:0] q0[$], q1[$], q2[$];

  function automatic int wof(int k);  return (k == 2) ? 16 : 8; endfunction
  function automatic bit sat(int k);  return k != 1; endfunction
  function automatic bit cos(int k);  return k == 2; endfunction
  function automatic longint cmax(int k); return (longint'(1) << wof(k)) - 1; endfunction
  function automatic longint val(int k, longint x);
    if (sat(k)) return (x > cmax(k)) ? cmax(k) : x;
    return x & cmax(k);
  endfunction

  function automatic int qsize(int k);
    if (k == 0) return q0.size();
    if (k == 1) return q1.size();
    return q2.size();
  endfunction
  function automatic logic [15:0] qfront(int k);
    if (k == 0) return q0[0];
    if (k == 1) return q1[0];
    return q2[0];
  endfunction
  task automatic qpush(int k, logic [15:0] v);
    if (k == 0) q0.push_back(v); else if (k == 1) q1.push_back(v); else q2.push_back(v);
  endtask
  task automatic qpop(int k);
    if (k == 0) void'(q0.pop_front()); else if (k == 1) void'(q1.pop_front()); else void'(q2.pop_front());
  endtask

  task automatic chk(string nm, int k, logic [15:0] act, logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s inst=%0d got=%h want=%h t=%0t", nm, k, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int k = 0; k < NI; k++) begin
      for (int i = 0; i < 7; i++) begin
        e[k][i]  = 0;
        sh[k][i] = 0;
      end
      ovf[k]  = '0;
      busy[k] = 1'b0;
    end
    q0.delete(); q1.delete(); q2.delete();
  endtask

  task automatic mon_one(int k);
    chk("req_ready", k, 16'(req_rdy[k]), 16'(!busy[k]));
    chk("resp_valid", k, 16'(resp_vld[k]), 16'(busy[k]));
    if (resp_vld[k]) begin
      if (qsize(k) == 0) begin
        checks++;
        failures++;
        $display("FAIL resp_unexpected inst=%0d got=%h want=none", k, dat[k]);
      end else begin
        chk("resp_data", k, dat[k], qfront(k));
        if (rrdy) qpop(k);
      end
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      for (int k = 0; k < NI; k++) mon_one(k);
    end
  end

  // Drive one cycle (called at posedge+1), predict the effect of the coming edge, commit after it.
  task automatic cycle(logic [6:0] v, logic c, logic s, logic rv, logic [2:0] ra, logic rr);
    longint     en  [NI][7];
    longint     shn [NI][7];
    logic [6:0] on  [NI];
    bit         bn  [NI];
    ev = v; clr = c; snap = s; rvld = rv; raddr = ra; rrdy = rr;
    for (int k = 0; k < NI; k++) begin
      if (!busy[k]) begin
        bn[k] = rv;
        if (rv) qpush(k, (ra == 3'd7) ? {9'b0, ovf[k]} : 16'(sh[k][ra]));
      end else begin
        bn[k] = !rr;
      end
      on[k] = c ? 7'b0 : ovf[k];
      for (int i = 0; i < 7; i++) begin
        shn[k][i] = s ? val(k, e[k][i]) : sh[k][i];
        if (c || (s && cos(k))) begin
          en[k][i] = longint'(v[i]);
        end else begin
          en[k][i] = e[k][i] + longint'(v[i]);
          if (v[i] && (e[k][i] + 1 > cmax(k))) on[k][i] = 1'b1;
        end
      end
    end
    @(posedge clk);
    for (int k = 0; k < NI; k++) begin
      for (int i = 0; i < 7; i++) begin
        e[k][i]  = en[k][i];
        sh[k][i] = shn[k][i];
      end
      ovf[k]  = on[k];
      busy[k] = bn[k];
    end
    #1;
  endtask

  task automatic rd(logic [2:0] a);
    cycle(7'h0, 1'b0, 1'b0, 1'b1, a, 1'b1);
    cycle(7'h0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1);
  endtask

  task automatic read_all();
    for (int a = 0; a < 8; a++) rd(3'(a));
  endtask

  task automatic idle(int n);
    repeat (n) cycle(7'h0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; ev = '0; clr = 1'b0; snap = 1'b0; rvld = 1'b0; raddr = '0; rrdy = 1'b0;
    mon_en = 1'b0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < NI; k++) begin
      chk("rst_req_ready", k, 16'(req_rdy[k]), 16'd1);
      chk("rst_resp_valid", k, 16'(resp_vld[k]), 16'd0);
      chk("rst_resp_data", k, dat[k], 16'd0);
    end
    rst = 1'b0;
    mon_en = 1'b1;

    // 5 good packets then snapshot
    repeat (5) cycle(7'h01, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1);
    cycle(7'h00, 1'b0, 1'b1, 1'b0, 3'd0, 1'b1);
    read_all();

    // all strobes together for 3 cycles
    cycle(7'h00, 1'b1, 1'b0, 1'b0, 3'd0, 1'b1);
    repeat (3) cycle(7'h7f, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1);
    cycle(7'h00, 1'b0, 1'b1, 1'b0, 3'd0, 1'b1);
    read_all();

    // 260 FCS errors: saturate / wrap / overflow flag, then clr+snap
    cycle(7'h00, 1'b1, 1'b0, 1'b0, 3'd0, 1'b1);
    repeat (260) cycle(7'h04, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1);
    cycle(7'h00, 1'b0, 1'b1, 1'b0, 3'd0, 1'b1);
    read_all();
    cycle(7'h00, 1'b1, 1'b1, 1'b0, 3'd0, 1'b1);
    cycle(7'h00, 1'b0, 1'b1, 1'b0, 3'd0, 1'b1);
    read_all();

    // snap+clr+strobe in one cycle, then a second snap
    cycle(7'h00, 1'b1, 1'b0, 1'b0, 3'd0, 1'b1);
    repeat (10) cycle(7'h01, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1);
    cycle(7'h01, 1'b1, 1'b1, 1'b0, 3'd0, 1'b1);
    rd(3'd0);
    cycle(7'h00, 1'b0, 1'b1, 1'b0, 3'd0, 1'b1);
    rd(3'd0);

    // snap with same-cycle strobe, then 2 more and snap again
    cycle(7'h00, 1'b1, 1'b0, 1'b0, 3'd0, 1'b1);
    repeat (4) cycle(7'h08, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1);
    cycle(7'h08, 1'b0, 1'b1, 1'b0, 3'd0, 1'b1);
    rd(3'd3);
    repeat (2) cycle(7'h08, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1);
    cycle(7'h00, 1'b0, 1'b1, 1'b0, 3'd0, 1'b1);
    rd(3'd3);

    // randomized traffic with varying strobe density
    for (int blk = 0; blk < 8; blk++) begin
      int dens;
      dens = int'($urandom_range(0, 3));
      repeat (500) begin
        logic [6:0] v;
        for (int i = 0; i < 7; i++) v[i] = (int'($urandom_range(0, 3)) < dens);
        cycle(v, ($urandom_range(0, 299) == 0), ($urandom_range(0, 15) == 0),
              ($urandom_range(0, 2) == 0), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
      end
    end
    idle(2);

    // response held under backpressure while snapping, then reset mid-response
    cycle(7'h00, 1'b0, 1'b1, 1'b0, 3'd0, 1'b1);
    cycle(7'h00, 1'b0, 1'b0, 1'b1, 3'd2, 1'b0);
    for (int n = 0; n < 10; n++) begin
      cycle(7'($urandom_range(0, 127)), 1'b0, (n % 3 == 0), 1'b0, 3'd0, 1'b0);
    end
    rst = 1'b1;
    #1;
    for (int k = 0; k < NI; k++) begin
      chk("midrst_resp_valid", k, 16'(resp_vld[k]), 16'd0);
      chk("midrst_req_ready", k, 16'(req_rdy[k]), 16'd1);
      chk("midrst_resp_data", k, dat[k], 16'd0);
    end
    model_clear();
    ev = '0; snap = 1'b0; rvld = 1'b0; rrdy = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    read_all();
    idle(2);

    for (int k = 0; k < NI; k++) chk("queue_drained", k, 16'(qsize(k)), 16'd0);

    mon_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
